// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared widths and FSM state encoding for the MEM stage
package mem_access_unit_pkg;
    localparam int WORD_LEN          = 32;
    localparam int REG_FILE_ADDR_LEN = 5;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: req/ack data-memory bus between the MEM stage and memory
interface mem_access_unit_if #(parameter int WORD_W = 32);
    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ack;
    modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
    modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_timeout_counter.sv
// mem_timeout_counter: counts waiting cycles and flags the last one before abort
module mem_timeout_counter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [CNT_W-1:0] cnt;
    // cleared outside an access, advances on each unacknowledged wait cycle
    always_ff @(posedge clk)
        cnt <= (rst | clr) ? '0 : en ? cnt + CNT_W'(1) : cnt;
    assign expired = cnt == CNT_W'(TIMEOUT - 1);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage turning load/store enables into a stalling req/ack access
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int WORD_W  = WORD_LEN,
    parameter int ADDR_W  = REG_FILE_ADDR_LEN,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_EN,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [WORD_W-1:0] PC,
    input  logic [WORD_W-1:0] ALURes,
    input  logic [WORD_W-1:0] STVal,
    input  logic [ADDR_W-1:0] dest,
    output logic              freeze,
    mem_access_unit_if.master bus,
    output logic              WB_EN_out,
    output logic              MEM_R_EN_out,
    output logic [WORD_W-1:0] ALURes_out,
    output logic [WORD_W-1:0] memData_out,
    output logic [ADDR_W-1:0] dest_out,
    output logic [WORD_W-1:0] PC_out,
    output logic              mem_err
);
    logic [1:0]        state;
    logic              acc, idle, busy, done, expired;
    logic              lat_wb, lat_r;
    logic [WORD_W-1:0] lat_alu, lat_pc, rdata_q;
    logic [ADDR_W-1:0] lat_dest;

    assign acc    = MEM_R_EN | MEM_W_EN;
    assign idle   = state == IDLE;
    assign busy   = state == BUSY;
    assign done   = state == DONE;
    assign freeze = (idle & acc) | busy;

    mem_timeout_counter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timeout (
        .clk(clk),
        .rst(rst),
        .clr(~busy),
        .en(busy & ~bus.mem_ack),
        .expired(expired)
    );

    // access FSM: launch from IDLE, wait for ack or timeout in BUSY, retire in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            mem_err       <= 1'b0;
            lat_wb        <= 1'b0;
            lat_r         <= 1'b0;
            lat_alu       <= '0;
            lat_pc        <= '0;
            lat_dest      <= '0;
            rdata_q       <= '0;
        end else if (idle & acc) begin
            state         <= BUSY;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= MEM_W_EN & ~MEM_R_EN;
            bus.mem_addr  <= {ALURes[WORD_W-1:2], 2'b00};
            bus.mem_wdata <= STVal;
            lat_wb        <= WB_EN;
            lat_r         <= MEM_R_EN;
            lat_alu       <= ALURes;
            lat_pc        <= PC;
            lat_dest      <= dest;
            if ((MEM_R_EN & MEM_W_EN) | (|ALURes[1:0]))
                mem_err <= 1'b1;
        end else if (busy & bus.mem_ack) begin
            state       <= DONE;
            bus.mem_req <= 1'b0;
            rdata_q     <= lat_r ? bus.mem_rdata : '0;
        end else if (busy & expired) begin
            state       <= DONE;
            bus.mem_req <= 1'b0;
            mem_err     <= 1'b1;
            rdata_q     <= '0;
            lat_wb      <= 1'b0;
        end else if (done) begin
            state <= IDLE;
        end
    end

    // MEM->WB register: bubble while frozen, retire latched access in DONE, else pass through
    always_ff @(posedge clk) begin
        if (rst) begin
            WB_EN_out    <= 1'b0;
            MEM_R_EN_out <= 1'b0;
            ALURes_out   <= '0;
            memData_out  <= '0;
            dest_out     <= '0;
            PC_out       <= '0;
        end else if (freeze) begin
            WB_EN_out    <= 1'b0;
            MEM_R_EN_out <= 1'b0;
        end else if (done) begin
            WB_EN_out    <= lat_wb;
            MEM_R_EN_out <= lat_r;
            ALURes_out   <= lat_alu;
            memData_out  <= rdata_q;
            dest_out     <= lat_dest;
            PC_out       <= lat_pc;
        end else begin
            WB_EN_out    <= WB_EN;
            MEM_R_EN_out <= MEM_R_EN;
            ALURes_out   <= ALURes;
            memData_out  <= '0;
            dest_out     <= dest;
            PC_out       <= PC;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of pass-through, load/store stalls, timeout, reset and errors
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        WB_EN, MEM_R_EN, MEM_W_EN;
    logic [31:0] PC, ALURes, STVal;
    logic [4:0]  dest;
    logic        freeze;
    logic        WB_EN_out, MEM_R_EN_out;
    logic [31:0] ALURes_out, memData_out, PC_out;
    logic [4:0]  dest_out;
    logic        mem_err;
    int          checks = 0;
    int          errors = 0;
    int          frz, nbusy;
    logic [31:0] snap_addr, snap_wdata;
    logic        snap_we, wb_stall;

    mem_access_unit_if #(.WORD_W(32)) bus ();

    mem_access_unit #(.WORD_W(32), .ADDR_W(5), .TIMEOUT(4), .CNT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .WB_EN(WB_EN),
        .MEM_R_EN(MEM_R_EN),
        .MEM_W_EN(MEM_W_EN),
        .PC(PC),
        .ALURes(ALURes),
        .STVal(STVal),
        .dest(dest),
        .freeze(freeze),
        .bus(bus),
        .WB_EN_out(WB_EN_out),
        .MEM_R_EN_out(MEM_R_EN_out),
        .ALURes_out(ALURes_out),
        .memData_out(memData_out),
        .dest_out(dest_out),
        .PC_out(PC_out),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic wb, input logic r, input logic w, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] st, input logic [4:0] d);
        WB_EN = wb; MEM_R_EN = r; MEM_W_EN = w; PC = pc; ALURes = alu; STVal = st; dest = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Plays memory: acks in the k-th BUSY cycle (k = 0 never acks); returns frozen and BUSY cycle counts
    task automatic run_mem(input int k, input logic [31:0] rd, output int f, output int nb);
        f = 0;
        nb = 0;
        wb_stall = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.mem_ack = bus.mem_req && (nb + 1 == k);
            bus.mem_rdata = rd;
            #1;
            if (!freeze) break;
            f++;
            if (bus.mem_req) begin
                if (nb == 0) begin
                    snap_addr = bus.mem_addr;
                    snap_we = bus.mem_we;
                    snap_wdata = bus.mem_wdata;
                end
                wb_stall = wb_stall | WB_EN_out;
                nb++;
            end
            tick();
            bus.mem_ack = 1'b0;
        end
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_req", bus.mem_req, 0);
        check("rst_freeze", freeze, 0);
        check("rst_err", mem_err, 0);
        check("rst_pc", PC_out, 0);

        drive(1, 0, 0, 32'h40, 32'h10, 0, 3);
        #1;
        check("alu_freeze", freeze, 0);
        tick();
        check("alu_wb", WB_EN_out, 1);
        check("alu_res", ALURes_out, 32'h10);
        check("alu_dest", dest_out, 3);
        check("alu_pc", PC_out, 32'h40);

        drive(1, 1, 0, 32'h44, 32'h100, 0, 7);
        run_mem(3, 32'hDEAD_BEEF, frz, nbusy);
        check("ld_freeze_cycles", frz, 4);
        check("ld_addr", snap_addr, 32'h100);
        check("ld_we", snap_we, 0);
        check("ld_wb_stall", wb_stall, 0);
        check("ld_done_req", bus.mem_req, 0);
        tick();
        check("ld_data", memData_out, 32'hDEAD_BEEF);
        check("ld_ren", MEM_R_EN_out, 1);
        check("ld_dest", dest_out, 7);
        check("ld_wb", WB_EN_out, 1);
        check("ld_err", mem_err, 0);

        drive(0, 0, 1, 32'h48, 32'h204, 32'h1234, 0);
        run_mem(1, 32'h5555_5555, frz, nbusy);
        check("st_freeze_cycles", frz, 2);
        check("st_we", snap_we, 1);
        check("st_wdata", snap_wdata, 32'h1234);
        check("st_addr", snap_addr, 32'h204);
        tick();
        check("st_wb", WB_EN_out, 0);
        check("st_data", memData_out, 0);
        check("st_alu", ALURes_out, 32'h204);

        drive(1, 1, 0, 32'h4C, 32'h300, 0, 9);
        run_mem(0, 32'h7777_7777, frz, nbusy);
        check("to_busy_cycles", nbusy, 4);
        check("to_freeze_cycles", frz, 5);
        check("to_req", bus.mem_req, 0);
        check("to_err", mem_err, 1);
        tick();
        check("to_wb", WB_EN_out, 0);
        check("to_data", memData_out, 0);
        check("to_dest", dest_out, 9);

        drive(1, 1, 0, 32'h50, 32'h400, 0, 4);
        tick();
        check("rb_req_up", bus.mem_req, 1);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        check("rb_req", bus.mem_req, 0);
        check("rb_freeze", freeze, 0);
        check("rb_err", mem_err, 0);
        check("rb_alu", ALURes_out, 0);
        check("rb_pc", PC_out, 0);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        tick();
        bus.mem_ack = 1'b0;
        tick();
        check("stray_req", bus.mem_req, 0);
        check("stray_data", memData_out, 0);
        check("stray_err", mem_err, 0);

        drive(1, 1, 1, 32'h54, 32'h103, 32'h99, 5);
        run_mem(2, 32'hCAFE_F00D, frz, nbusy);
        check("ill_freeze_cycles", frz, 3);
        check("ill_we", snap_we, 0);
        check("ill_addr", snap_addr, 32'h100);
        check("ill_err", mem_err, 1);
        tick();
        check("ill_data", memData_out, 32'hCAFE_F00D);
        check("ill_ren", MEM_R_EN_out, 1);
        drive(1, 0, 0, 32'h58, 32'h20, 0, 2);
        tick();
        check("sticky_err", mem_err, 1);
        check("sticky_wb", WB_EN_out, 1);
        check("sticky_alu", ALURes_out, 32'h20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("err_cleared", mem_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage consumer of the EXE→MEM pipeline register outputs. It turns each instruction's memory enables into a req/ack transaction on a variable-latency data-memory bus and stalls the front of the pipeline while the access is outstanding. It drives registered MEM→WB outputs (write enable, ALU result, load data, destination, PC) and inserts a bubble on every frozen cycle.

Parameters:
WORD_W, 32 (`WORD_LEN), datapath width
ADDR_W, 5 (`REG_FILE_ADDR_LEN), register-file address width
TIMEOUT, 64, max cycles in BUSY before abort; must be >= 1
CNT_W, 7, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
WB_EN  in  1  writeback enable from EXE→MEM register
MEM_R_EN  in  1  load request
MEM_W_EN  in  1  store request
PC  in  WORD_W  instruction PC
ALURes  in  WORD_W  effective address / ALU result
STVal  in  WORD_W  store data
dest  in  ADDR_W  destination register
freeze  out  1  combinational stall to PC, IF/ID, ID/EXE, EXE/MEM registers
mem_req  out  1  memory request, registered
mem_we  out  1  1 = write, registered
mem_addr  out  WORD_W  word-aligned address, registered
mem_wdata  out  WORD_W  store data, registered
mem_rdata  in  WORD_W  load data, valid when mem_ack = 1
mem_ack  in  1  one-cycle completion pulse
WB_EN_out  out  1  MEM→WB writeback enable, registered
MEM_R_EN_out  out  1  MEM→WB load select, registered
ALURes_out  out  WORD_W  registered
memData_out  out  WORD_W  registered load data
dest_out  out  ADDR_W  registered
PC_out  out  WORD_W  registered
mem_err  out  1  sticky error flag; cleared only by rst

Behaviour:
- Reset: all registered outputs, state and counter go to 0; state = IDLE. Reset mid-transaction aborts it: mem_req = 0 after the reset edge and no ack is honoured.
- acc = MEM_R_EN | MEM_W_EN.
- freeze = (IDLE & acc) | BUSY. freeze is 0 in DONE.
- IDLE:
  - acc = 0: output registers load the inputs each edge, with memData_out = 0 (latency 1).
  - acc = 1: latch the instruction fields into internal registers. Set mem_req = 1, mem_we = MEM_W_EN & ~MEM_R_EN, mem_addr = {ALURes[W-1:2], 2'b00}, mem_wdata = STVal. Counter = 0. Next state BUSY.
- BUSY: mem_req and the other bus outputs are held stable.
  - mem_ack = 1: capture mem_rdata (loads only), mem_req <= 0, next state DONE.
  - Otherwise counter increments. When counter == TIMEOUT-1 and there is no ack: mem_req <= 0, mem_err <= 1, captured data = 0, latched WB_EN forced 0, next state DONE.
- DONE: output registers load the latched fields plus captured data; next state IDLE. The upstream pipeline advances on this same edge.
- Bubble rule: every edge with freeze = 1 loads WB_EN_out = 0 and MEM_R_EN_out = 0. The other outputs hold.
- Illegal MEM_R_EN & MEM_W_EN: the access is performed as a read and mem_err <= 1.
- Misaligned ALURes[1:0] != 0: the address is aligned down and mem_err <= 1; the access still proceeds.
- mem_ack outside BUSY is ignored.
- An ack arriving on the same cycle the counter would expire wins (normal completion).
- Throughput: a non-memory op retires 1 per cycle. A memory op with ack k cycles after mem_req rises takes 2+k cycles. A back-to-back memory op re-enters BUSY directly through IDLE.

Decomposition:
- Shared package/defines file: `WORD_LEN and `REG_FILE_ADDR_LEN, plus the state encoding constants IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2.
- One natural sub-module, mem_timeout_counter: clear, enable, expired flag, parameterised by TIMEOUT.

Test Plan:
- ALU op flow: WB_EN=1, MEM_R_EN=0, ALURes=0x0000_0010, dest=3 → next edge WB_EN_out=1, ALURes_out=0x10, dest_out=3; freeze stays 0.
- Load with 3-cycle ack:
  - Stimulus: MEM_R_EN=1, ALURes=0x100, dest=7; memory returns 0xDEAD_BEEF.
  - freeze=1 for 4 cycles; mem_req high with mem_addr=0x100, mem_we=0.
  - WB_EN_out=0 during the stall. After DONE: memData_out=0xDEAD_BEEF, MEM_R_EN_out=1, dest_out=7.
- Store with immediate ack: MEM_W_EN=1, ALURes=0x204, STVal=0x1234 → mem_we=1, mem_wdata=0x1234; acked the cycle after mem_req rises; total freeze 2 cycles; WB_EN_out=0.
- Timeout: TIMEOUT=4, load, never ack → mem_req drops after 4 BUSY cycles; mem_err=1; WB_EN_out=0 and memData_out=0 after DONE.
- Reset in BUSY: assert rst while mem_req=1 → next edge mem_req=0, freeze=0, all outputs 0; a later stray mem_ack has no effect.
- Illegal and misaligned: MEM_R_EN=MEM_W_EN=1, ALURes=0x103 → mem_we=0, mem_addr=0x100, mem_err=1 sticky until rst.
